// File: rtl/stream_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter_if
// Bundles every slave-side and FIFO-side signal of the round-robin stream
// arbiter so the arbiter and its environment connect through one port.
//
// Signals (channel i of a packed per-slave vector lives at [i*W +: W]):
//   slv_mode        per-slave mode, 0 = channel not requesting
//   slv_data_valid  per-slave beat valid
//   slv_data        per-slave beat data
//   slv_proc_val    per-slave processing value
//   slv_last        per-slave end-of-packet flag (qualified by valid)
//   slv_ready       per-slave ready, one-hot or zero
//   fifo_full       downstream FIFO full
//   mstr_cmplt      master complete, stalls every transfer
//   slvx_*          registered merged beat toward the FIFO
//   data_source     channel index that produced the merged beat
//   busy            arbiter currently holds a grant
//
// Modports:
//   master  the arbiter itself
//   slave   the environment (slave streams, FIFO, master)
// -----------------------------------------------------------------------------
interface stream_rr_arbiter_if #(
  parameter int NUM_SLV = 4,
  parameter int DW      = 32,
  parameter int PW      = 8,
  parameter int MW      = 2
);

  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  logic [NUM_SLV*MW-1:0] slv_mode;
  logic [NUM_SLV-1:0]    slv_data_valid;
  logic [NUM_SLV*DW-1:0] slv_data;
  logic [NUM_SLV*PW-1:0] slv_proc_val;
  logic [NUM_SLV-1:0]    slv_last;
  logic [NUM_SLV-1:0]    slv_ready;
  logic                  fifo_full;
  logic                  mstr_cmplt;
  logic                  slvx_data_valid;
  logic [DW-1:0]         slvx_data;
  logic [MW-1:0]         slvx_mode;
  logic [PW-1:0]         slvx_proc_val;
  logic                  slvx_last;
  logic [SW-1:0]         data_source;
  logic                  busy;

  modport master (
    input  slv_mode, slv_data_valid, slv_data, slv_proc_val, slv_last,
    input  fifo_full, mstr_cmplt,
    output slv_ready, slvx_data_valid, slvx_data, slvx_mode, slvx_proc_val,
    output slvx_last, data_source, busy
  );

  modport slave (
    output slv_mode, slv_data_valid, slv_data, slv_proc_val, slv_last,
    output fifo_full, mstr_cmplt,
    input  slv_ready, slvx_data_valid, slvx_data, slvx_mode, slvx_proc_val,
    input  slvx_last, data_source, busy
  );

endinterface

// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
// Merges NUM_SLV image-data slave streams into one registered stream toward
// the processing FIFO. Grants are round-robin at packet granularity with an
// optional cap of MAX_BURST beats per grant (0 = no cap). FIFO full and
// master-complete drop the granted channel's ready without losing the grant.
// Every merged beat carries the index of the channel it came from.
//
// Ports:
//   clk     clock
//   rst     asynchronous reset, active-high
//   arb_io  stream_rr_arbiter_if.master carrying all slave/FIFO signals
// -----------------------------------------------------------------------------
module stream_rr_arbiter #(
  parameter int NUM_SLV   = 4,
  parameter int DW        = 32,
  parameter int PW        = 8,
  parameter int MW        = 2,
  parameter int MAX_BURST = 0
) (
  input logic                  clk,
  input logic                  rst,
  stream_rr_arbiter_if.master  arb_io
);

  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] grant_q, grant_d;
  logic [SW-1:0] rrPtr_q, rrPtr_d;
  logic [CW-1:0] beatCnt_q, beatCnt_d;

  logic          outValid_q;
  logic [DW-1:0] outData_q;
  logic [MW-1:0] outMode_q;
  logic [PW-1:0] outProc_q;
  logic          outLast_q;
  logic [SW-1:0] outSrc_q;

  logic [NUM_SLV-1:0] req;
  logic               anyReq;
  logic [SW-1:0]      pick;
  logic               selValid;
  logic [DW-1:0]      selData;
  logic [MW-1:0]      selMode;
  logic [PW-1:0]      selProc;
  logic               selLast;
  logic               grantReady;
  logic [NUM_SLV-1:0] readyVec;
  logic               accept;
  logic               capHit;
  logic               modeDrop;

  // A channel requests whenever its mode is non-zero.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      req[i] = |arb_io.slv_mode[i*MW +: MW];
    end
  end

  // Round-robin pick: scan from the slot after the last winner and wrap, so
  // the last winner is considered last and can never starve the others.
  always_comb begin : rrSearch
    logic [SW-1:0] cand;
    anyReq = 1'b0;
    pick   = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_SLV; k++) begin
      cand = SW'((int'(rrPtr_q) + k) % NUM_SLV);
      if (!anyReq && req[cand]) begin
        anyReq = 1'b1;
        pick   = cand;
      end
    end
  end

  // Steer the granted channel's inputs and build the one-hot ready vector.
  // The ready is combinational from the registered grant so back-pressure
  // removes it in the same cycle it appears.
  always_comb begin
    selValid   = 1'b0;
    selData    = '0;
    selMode    = '0;
    selProc    = '0;
    selLast    = 1'b0;
    readyVec   = '0;
    grantReady = (state_q == GRANT) && !arb_io.fifo_full && !arb_io.mstr_cmplt;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (grant_q == SW'(i)) begin
        selValid    = arb_io.slv_data_valid[i];
        selData     = arb_io.slv_data[i*DW +: DW];
        selMode     = arb_io.slv_mode[i*MW +: MW];
        selProc     = arb_io.slv_proc_val[i*PW +: PW];
        selLast     = arb_io.slv_last[i];
        readyVec[i] = grantReady;
      end
    end
  end

  // Handshake and release qualifiers for the current grant. A mode drop is
  // ignored while the master-complete stall is active so the grant is kept.
  always_comb begin
    accept   = grantReady && selValid;
    capHit   = (MAX_BURST != 0) && ((beatCnt_q + 1'b1) == BURST_LIM);
    modeDrop = (state_q == GRANT) && (selMode == '0) && !arb_io.mstr_cmplt;
  end

  // Next-state logic: IDLE spends exactly one cycle arbitrating, GRANT holds
  // the winner until end of packet, burst cap, or mode drop.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rrPtr_d   = rrPtr_q;
    beatCnt_d = beatCnt_q;
    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          state_d   = GRANT;
          grant_d   = pick;
          rrPtr_d   = pick;
          beatCnt_d = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          beatCnt_d = beatCnt_q + 1'b1;
        end
        if ((accept && (selLast || capHit)) || modeDrop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration state registers; the pointer starts at the last channel so
  // the first scan after reset begins at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rrPtr_q   <= SW'(NUM_SLV - 1);
      beatCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rrPtr_q   <= rrPtr_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  // Output beat register: one-cycle latency after accept; the payload and
  // source hold their last values while no beat is being emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outMode_q  <= '0;
      outProc_q  <= '0;
      outLast_q  <= 1'b0;
      outSrc_q   <= '0;
    end else begin
      outValid_q <= accept;
      if (accept) begin
        outData_q <= selData;
        outMode_q <= selMode;
        outProc_q <= selProc;
        outLast_q <= selLast;
        outSrc_q  <= grant_q;
      end
    end
  end

  assign arb_io.slv_ready       = readyVec;
  assign arb_io.slvx_data_valid = outValid_q;
  assign arb_io.slvx_data       = outData_q;
  assign arb_io.slvx_mode       = outMode_q;
  assign arb_io.slvx_proc_val   = outProc_q;
  assign arb_io.slvx_last       = outLast_q;
  assign arb_io.data_source     = outSrc_q;
  assign arb_io.busy            = (state_q == GRANT);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_rr_arbiter
// Self-checking bench for stream_rr_arbiter (4 channels, burst cap of 2).
// Slave channels are modelled as simple packet generators; expected merged
// beats are queued as each scenario is set up and compared as they appear.
// -----------------------------------------------------------------------------
module tb_stream_rr_arbiter;

  localparam int NUM_SLV   = 4;
  localparam int DW        = 32;
  localparam int PW        = 8;
  localparam int MW        = 2;
  localparam int MAX_BURST = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [MW-1:0] mode;
    logic [PW-1:0] proc;
    logic          last;
    logic [1:0]    src;
  } beat_t;

  typedef struct {
    logic [3:0] reqMask;
    logic [3:0] expReady;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stream_rr_arbiter_if #(.NUM_SLV(NUM_SLV), .DW(DW), .PW(PW), .MW(MW)) bus ();

  stream_rr_arbiter #(
    .NUM_SLV(NUM_SLV), .DW(DW), .PW(PW), .MW(MW), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb_io(bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCnt    = 0;

  beat_t expQ[$];
  int    outTimes[$];

  logic [3:0]    active;
  logic [3:0]    validEn;
  logic [3:0]    lastReady;
  logic [3:0]    hs;
  int            idx[4];
  int            len[4];
  int            pkts[4];
  int            step[4];
  logic [DW-1:0] base[4];
  logic [MW-1:0] modeVal[4];

  vec_t vecs[8];

  // Single comparison point: every check counts once and reports on failure.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Queue the beat a channel will present at packet index bi.
  function automatic void pushBeat(input int ch, input int bi);
    beat_t e;
    e.data = base[ch] + DW'(step[ch] * bi);
    e.mode = modeVal[ch];
    e.proc = PW'(ch * 16 + bi);
    e.last = (bi == len[ch] - 1);
    e.src  = 2'(ch);
    expQ.push_back(e);
  endfunction

  function automatic void clearModel();
    active  = '0;
    validEn = '0;
    for (int ch = 0; ch < NUM_SLV; ch++) begin
      idx[ch]     = 0;
      len[ch]     = 1;
      pkts[ch]    = 1;
      step[ch]    = 1;
      base[ch]    = '0;
      modeVal[ch] = MW'((ch % 3) + 1);
    end
    bus.fifo_full  = 1'b0;
    bus.mstr_cmplt = 1'b0;
  endfunction

  // Drive every slave channel from the packet-generator model.
  task automatic applyStimulus();
    for (int ch = 0; ch < NUM_SLV; ch++) begin
      bus.slv_mode[ch*MW +: MW]     = active[ch] ? modeVal[ch] : '0;
      bus.slv_data_valid[ch]        = active[ch] & validEn[ch];
      bus.slv_data[ch*DW +: DW]     = base[ch] + DW'(step[ch] * idx[ch]);
      bus.slv_proc_val[ch*PW +: PW] = PW'(ch * 16 + idx[ch]);
      bus.slv_last[ch]              = (idx[ch] == len[ch] - 1);
    end
  endtask

  // One clock: drive at the falling edge, note the handshake just before the
  // rising edge, and advance the slave model at the next falling edge.
  task automatic stepCycle();
    applyStimulus();
    #1;
    lastReady = bus.slv_ready;
    hs        = lastReady & bus.slv_data_valid;
    @(negedge clk);
    for (int ch = 0; ch < NUM_SLV; ch++) begin
      if (hs[ch]) begin
        idx[ch]++;
        if (idx[ch] == len[ch]) begin
          idx[ch] = 0;
          if (pkts[ch] > 1) pkts[ch]--;
          else active[ch] = 1'b0;
        end
      end
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearModel();
    applyStimulus();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Run until all expected beats came out, bounded by a cycle budget.
  task automatic drain(input string name, input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      stepCycle();
      n++;
    end
    repeat (2) stepCycle();
    checkOutput(name, expQ.size(), 0);
  endtask

  // Output monitor: every merged beat must match the head of the queue.
  always @(negedge clk) begin : monitor
    beat_t e;
    cycleCnt++;
    if (!rst && bus.slvx_data_valid) begin
      outTimes.push_back(cycleCnt);
      if (expQ.size() == 0) begin
        checkOutput("unexpected beat", bus.slvx_data, 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("beat data", bus.slvx_data, e.data);
        checkOutput("beat mode", 32'(bus.slvx_mode), 32'(e.mode));
        checkOutput("beat proc", 32'(bus.slvx_proc_val), 32'(e.proc));
        checkOutput("beat last", 32'(bus.slvx_last), 32'(e.last));
        checkOutput("beat source", 32'(bus.data_source), 32'(e.src));
      end
    end
  end

  initial begin
    // Arbitration vectors from IDLE, each starting where the previous left
    // the round-robin pointer (3 after reset).
    vecs[0] = '{4'b1111, 4'b0001};
    vecs[1] = '{4'b1111, 4'b0010};
    vecs[2] = '{4'b0011, 4'b0001};
    vecs[3] = '{4'b1000, 4'b1000};
    vecs[4] = '{4'b1001, 4'b0001};
    vecs[5] = '{4'b0101, 4'b0100};
    vecs[6] = '{4'b0100, 4'b0100};
    vecs[7] = '{4'b1010, 4'b1000};

    // Reset with every slave requesting and valid.
    rst = 1'b1;
    clearModel();
    active  = 4'b1111;
    validEn = 4'b1111;
    applyStimulus();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset ready", 32'(bus.slv_ready), 0);
    checkOutput("reset out valid", 32'(bus.slvx_data_valid), 0);
    checkOutput("reset busy", 32'(bus.busy), 0);
    checkOutput("reset data", bus.slvx_data, 0);
    @(negedge clk);
    clearModel();
    applyStimulus();
    rst = 1'b0;

    // Table-driven arbitration order.
    for (int v = 0; v < 8; v++) begin
      active  = vecs[v].reqMask;
      validEn = '0;
      stepCycle();
      checkOutput($sformatf("vec%0d busy", v), 32'(bus.busy), 1);
      checkOutput($sformatf("vec%0d ready", v), 32'(bus.slv_ready), 32'(vecs[v].expReady));
      active = '0;
      stepCycle();
      checkOutput($sformatf("vec%0d release", v), 32'(bus.busy), 0);
    end

    // Round-robin over all four channels with 2-beat packets.
    doReset();
    outTimes.delete();
    for (int ch = 0; ch < NUM_SLV; ch++) begin
      base[ch] = DW'(32'hA0 + ch);
      step[ch] = 0;
      len[ch]  = 2;
    end
    pkts[0] = 2;
    active  = 4'b1111;
    validEn = 4'b1111;
    for (int ch = 0; ch < NUM_SLV; ch++) begin
      pushBeat(ch, 0);
      pushBeat(ch, 1);
    end
    pushBeat(0, 0);
    pushBeat(0, 1);
    stepCycle();
    checkOutput("rr arb cycle no beat", 32'(bus.slvx_data_valid), 0);
    stepCycle();
    checkOutput("rr first beat latency", 32'(bus.slvx_data_valid), 1);
    drain("rr drain", 40);
    checkOutput("rr beat count", outTimes.size(), 10);
    for (int i = 1; i < outTimes.size(); i++) begin
      checkOutput($sformatf("rr spacing %0d", i), outTimes[i] - outTimes[i-1],
                  (i % 2 == 1) ? 1 : 2);
    end

    // FIFO full for three cycles in the middle of a 4-beat ch1 packet.
    doReset();
    base[1]   = 32'h11;
    len[1]    = 4;
    active[1] = 1'b1;
    validEn   = 4'b0010;
    for (int b = 0; b < 4; b++) pushBeat(1, b);
    stepCycle();
    stepCycle();
    bus.fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput($sformatf("full ready %0d", c), 32'(lastReady[1]), 0);
      checkOutput($sformatf("full no beat %0d", c), 32'(bus.slvx_data_valid), 0);
      checkOutput($sformatf("full busy %0d", c), 32'(bus.busy), 1);
    end
    bus.fifo_full = 1'b0;
    drain("fifo full drain", 30);

    // Burst cap: ch0 5-beat packet is cut every 2 beats, ch2 slots in.
    doReset();
    base[0] = 32'h100;
    len[0]  = 5;
    base[2] = 32'h200;
    len[2]  = 2;
    active  = 4'b0101;
    validEn = 4'b0101;
    pushBeat(0, 0);
    pushBeat(0, 1);
    pushBeat(2, 0);
    pushBeat(2, 1);
    pushBeat(0, 2);
    pushBeat(0, 3);
    pushBeat(0, 4);
    drain("burst cap drain", 40);

    // Mode drop without a beat releases the grant.
    doReset();
    active[3] = 1'b1;
    stepCycle();
    checkOutput("mode grant busy", 32'(bus.busy), 1);
    checkOutput("mode grant ready", 32'(bus.slv_ready), 32'h8);
    active[3] = 1'b0;
    stepCycle();
    checkOutput("mode drop busy", 32'(bus.busy), 0);
    checkOutput("mode drop no beat", 32'(bus.slvx_data_valid), 0);
    // Same drop under master-complete keeps the grant with ready low.
    active[3] = 1'b1;
    stepCycle();
    bus.mstr_cmplt = 1'b1;
    active[3]      = 1'b0;
    stepCycle();
    checkOutput("mstr hold ready", 32'(lastReady[3]), 0);
    checkOutput("mstr hold busy", 32'(bus.busy), 1);
    bus.mstr_cmplt = 1'b0;
    stepCycle();
    checkOutput("mstr clear release", 32'(bus.busy), 0);

    // Asynchronous reset in the middle of a ch2 packet.
    doReset();
    base[2]   = 32'h20;
    len[2]    = 4;
    active[2] = 1'b1;
    validEn   = 4'b0100;
    pushBeat(2, 0);
    stepCycle();
    stepCycle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst out valid", 32'(bus.slvx_data_valid), 0);
    checkOutput("async rst data", bus.slvx_data, 0);
    checkOutput("async rst source", 32'(bus.data_source), 0);
    checkOutput("async rst busy", 32'(bus.busy), 0);
    checkOutput("async rst ready", 32'(bus.slv_ready), 0);
    checkOutput("async rst queue", expQ.size(), 0);
    clearModel();
    active = 4'b0101;
    applyStimulus();
    @(negedge clk);
    rst = 1'b0;
    stepCycle();
    checkOutput("restart grant ch0", 32'(bus.slv_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
